// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Which core port owns the transaction in flight
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arbState_t;

endpackage

// File: rtl/mem_port_arbiter_select.sv
// Combinational winner selection: data has priority unless the fetch port
// has already been passed over the maximum number of times in a row.
module mem_port_arbiter_select (
  input  logic dReq,
  input  logic iReq,
  input  logic streakSat,
  output logic grantD,
  output logic grantI
);

  assign grantD = dReq && !(iReq && streakSat);
  assign grantI = iReq && !grantD;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and
// load/store. One transaction in flight; responses go back to the issuer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  input  logic              IFlush,
  output logic              IReady,
  output logic              IValid,
  output logic [DATA_W-1:0] IRdata,
  output logic              IErr,
  input  logic              DReq,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [BE_W-1:0]   DWe,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DReady,
  output logic              DValid,
  output logic [DATA_W-1:0] DRdata,
  output logic              DErr,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [BE_W-1:0]   MemWe,
  output logic [DATA_W-1:0] MemWdata,
  input  logic              MemGnt,
  input  logic              MemRvalid,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              Busy
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int TIMER_W  = $clog2(TIMEOUT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT);

  arbState_t           stateReg;
  logic                ownerReg;
  logic                dropReg;
  logic                respErrReg;
  logic [DATA_W-1:0]   respDataReg;
  logic [STREAK_W-1:0] streakReg;
  logic [TIMER_W-1:0]  timerReg;
  logic                streakSat;
  logic                grantD;
  logic                grantI;
  logic                fetchFlushed;

  assign streakSat = (streakReg == STREAK_MAX);
  // A flush in the RESP cycle itself still suppresses the fetch response
  assign fetchFlushed = dropReg || IFlush;

  mem_port_arbiter_select uSelect (
    .dReq      (DReq),
    .iReq      (IReq),
    .streakSat (streakSat),
    .grantD    (grantD),
    .grantI    (grantI)
  );

  // Starvation counter: counts data grants that passed over a waiting fetch
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      streakReg <= '0;
    end else if (stateReg == ST_IDLE) begin
      if (grantI) begin
        streakReg <= '0;
      end else if (grantD) begin
        if (!IReq)
          streakReg <= '0;
        else if (!streakSat)
          streakReg <= streakReg + 1'b1;
      end
    end
  end

  // Transaction FSM with registered bus payload, handshakes and responses
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateReg    <= ST_IDLE;
      ownerReg    <= OWNER_I;
      dropReg     <= 1'b0;
      respErrReg  <= 1'b0;
      respDataReg <= '0;
      timerReg    <= '0;
      IReady      <= 1'b0;
      IValid      <= 1'b0;
      IRdata      <= '0;
      IErr        <= 1'b0;
      DReady      <= 1'b0;
      DValid      <= 1'b0;
      DRdata      <= '0;
      DErr        <= 1'b0;
      MemReq      <= 1'b0;
      MemAddr     <= '0;
      MemWe       <= '0;
      MemWdata    <= '0;
      Busy        <= 1'b0;
    end else begin
      // Handshake and response outputs are single-cycle pulses
      IReady <= 1'b0;
      DReady <= 1'b0;
      IValid <= 1'b0;
      IRdata <= '0;
      IErr   <= 1'b0;
      DValid <= 1'b0;
      DRdata <= '0;
      DErr   <= 1'b0;

      case (stateReg)
        ST_IDLE: begin
          if (grantD || grantI) begin
            stateReg <= ST_REQ;
            Busy     <= 1'b1;
            MemReq   <= 1'b1;
            dropReg  <= 1'b0;
            if (grantD) begin
              ownerReg <= OWNER_D;
              MemAddr  <= DAddr;
              MemWe    <= DWe;
              MemWdata <= DWdata;
              DReady   <= 1'b1;
            end else begin
              ownerReg <= OWNER_I;
              MemAddr  <= IAddr;
              MemWe    <= '0;
              MemWdata <= '0;
              IReady   <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          if (ownerReg == OWNER_I && IFlush)
            dropReg <= 1'b1;
          if (MemGnt) begin
            MemReq   <= 1'b0;
            MemAddr  <= '0;
            MemWe    <= '0;
            MemWdata <= '0;
            if (MemRvalid) begin
              respDataReg <= MemRdata;
              respErrReg  <= 1'b0;
              stateReg    <= ST_RESP;
            end else begin
              timerReg <= '0;
              stateReg <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (ownerReg == OWNER_I && IFlush)
            dropReg <= 1'b1;
          timerReg <= timerReg + 1'b1;
          if (MemRvalid) begin
            respDataReg <= MemRdata;
            respErrReg  <= 1'b0;
            stateReg    <= ST_RESP;
          end else if ((timerReg + 1'b1) == TIMER_LAST) begin
            respDataReg <= '0;
            respErrReg  <= 1'b1;
            stateReg    <= ST_RESP;
          end
        end

        ST_RESP: begin
          stateReg <= ST_IDLE;
          Busy     <= 1'b0;
          dropReg  <= 1'b0;
          if (ownerReg == OWNER_D) begin
            DValid <= 1'b1;
            DRdata <= respDataReg;
            DErr   <= respErrReg;
          end else if (!fetchFlushed) begin
            IValid <= 1'b1;
            IRdata <= respDataReg;
            IErr   <= respErrReg;
          end
        end

        default: stateReg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 255;

  typedef struct {
    bit          isData;
    logic [31:0] data;
    bit          err;
    bit          chkData;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        IReq, IFlush, DReq;
  logic [31:0] IAddr, DAddr, DWdata, MemRdata;
  logic [3:0]  DWe;
  logic        IReady, IValid, IErr, DReady, DValid, DErr;
  logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
  logic [3:0]  MemWe;
  logic        MemReq, MemGnt, MemRvalid, Busy;
  logic        gntDrv, rvDrv, autoBus;

  int          checks = 0;
  int          errors = 0;
  sbEntry_t    sbQ[$];
  sbEntry_t    monEntry;
  bit          gotD;
  int          validAt;
  bit          expOrder[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  // Simple bus: directed gnt/rvalid, or zero-wait response when autoBus is set
  assign MemGnt    = gntDrv | (autoBus & MemReq);
  assign MemRvalid = rvDrv  | (autoBus & MemReq);

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_STREAK(4), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RESET(rst),
    .IReq(IReq), .IAddr(IAddr), .IFlush(IFlush),
    .IReady(IReady), .IValid(IValid), .IRdata(IRdata), .IErr(IErr),
    .DReq(DReq), .DAddr(DAddr), .DWe(DWe), .DWdata(DWdata),
    .DReady(DReady), .DValid(DValid), .DRdata(DRdata), .DErr(DErr),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemWe(MemWe), .MemWdata(MemWdata),
    .MemGnt(MemGnt), .MemRvalid(MemRvalid), .MemRdata(MemRdata),
    .Busy(Busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(output bit isD);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(IReady || DReady) && n < 20);
    check("ready_seen", {31'd0, IReady | DReady}, 32'd1);
    check("ready_excl", {31'd0, IReady & DReady}, 32'd0);
    isD = DReady;
    $display("grant: port=%s addr=%h we=%b", DReady ? "D" : "I", MemAddr, MemWe);
  endtask

  // Scoreboard: every Valid pulse must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && (IValid || DValid)) begin
      check("sb_nonempty", {31'd0, sbQ.size() != 0}, 32'd1);
      check("valid_excl", {31'd0, IValid & DValid}, 32'd0);
      check("ready_valid_i", {31'd0, IValid & IReady}, 32'd0);
      check("ready_valid_d", {31'd0, DValid & DReady}, 32'd0);
      if (sbQ.size() != 0) begin
        monEntry = sbQ.pop_front();
        check("resp_port", {31'd0, DValid}, {31'd0, monEntry.isData});
        if (DValid) begin
          check("resp_derr", {31'd0, DErr}, {31'd0, monEntry.err});
          if (monEntry.chkData) check("resp_drdata", DRdata, monEntry.data);
        end else begin
          check("resp_ierr", {31'd0, IErr}, {31'd0, monEntry.err});
          if (monEntry.chkData) check("resp_irdata", IRdata, monEntry.data);
        end
      end
      $display("resp: port=%s data=%h err=%b", DValid ? "D" : "I",
               DValid ? DRdata : IRdata, DValid ? DErr : IErr);
    end
  end

  initial begin
    rst = 1'b1; IReq = 0; IFlush = 0; DReq = 0; IAddr = 0; DAddr = 0; DWe = 0;
    DWdata = 0; MemRdata = 0; gntDrv = 0; rvDrv = 0; autoBus = 0;
    #1;
    check("reset_ctrl", {24'd0, IReady, IValid, IErr, DReady, DValid, DErr, MemReq, Busy}, 32'd0);
    check("reset_addr", MemAddr, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: fetch, gnt with request, rvalid two cycles later
    IReq = 1; IAddr = 32'h0000_0400;
    tick();
    check("t1_iready", {31'd0, IReady}, 32'd1);
    check("t1_memreq", {31'd0, MemReq}, 32'd1);
    check("t1_memaddr", MemAddr, 32'h0000_0400);
    check("t1_memwe", {28'd0, MemWe}, 32'd0);
    sbQ.push_back('{1'b0, 32'h0000_0013, 1'b0, 1'b1});
    IReq = 0; gntDrv = 1;
    tick();                               // t1
    gntDrv = 0;
    check("t1_memreq_drop", {31'd0, MemReq}, 32'd0);
    check("t1_memaddr_zero", MemAddr, 32'd0);
    tick();                               // t2
    rvDrv = 1; MemRdata = 32'h0000_0013;
    tick();                               // t3
    rvDrv = 0;
    check("t1_no_early_ivalid", {31'd0, IValid}, 32'd0);
    check("t1_busy_resp", {31'd0, Busy}, 32'd1);
    tick();                               // t4
    check("t1_ivalid_t4", {31'd0, IValid}, 32'd1);
    check("t1_irdata", IRdata, 32'h0000_0013);
    check("t1_busy_idle", {31'd0, Busy}, 32'd0);

    // 2: both ports held, zero-wait bus
    IAddr = 32'h0000_1000; DAddr = 32'h0000_2000; DWe = 0; DWdata = 0;
    MemRdata = 32'hCAFE_0000; autoBus = 1; DReq = 1; IReq = 1;
    for (int k = 0; k < 6; k++) begin
      waitReady(gotD);
      check("t2_order", {31'd0, gotD}, {31'd0, expOrder[k]});
      check("t2_addr", MemAddr, gotD ? 32'h0000_2000 : 32'h0000_1000);
      sbQ.push_back('{gotD, 32'hCAFE_0000, 1'b0, 1'b1});
    end
    DReq = 0; IReq = 0;
    tick(); tick(); tick();
    autoBus = 0;

    // 3: partial store
    DReq = 1; DAddr = 32'h1001_0002; DWe = 4'b0011; DWdata = 32'hDEAD_BEEF;
    tick();
    check("t3_dready", {31'd0, DReady}, 32'd1);
    check("t3_memwe", {28'd0, MemWe}, 32'h3);
    check("t3_memaddr", MemAddr, 32'h1001_0002);
    check("t3_memwdata", MemWdata, 32'hDEAD_BEEF);
    sbQ.push_back('{1'b1, 32'd0, 1'b0, 1'b0});
    DReq = 0; DWe = 0; gntDrv = 1;
    tick();
    gntDrv = 0;
    check("t3_memwe_zero", {28'd0, MemWe}, 32'd0);
    tick();
    rvDrv = 1; MemRdata = 32'h5555_5555;
    tick();
    rvDrv = 0;
    tick();
    check("t3_dvalid", {31'd0, DValid}, 32'd1);

    // 4: fetch flushed while waiting, then a normal data read
    IReq = 1; IAddr = 32'h0000_2000;
    tick();
    check("t4_iready", {31'd0, IReady}, 32'd1);
    IReq = 0; gntDrv = 1;
    tick();
    gntDrv = 0; IFlush = 1;
    tick();
    IFlush = 0;
    tick();
    rvDrv = 1; MemRdata = 32'h1111_1111;
    tick();
    rvDrv = 0;
    check("t4_busy_resp", {31'd0, Busy}, 32'd1);
    tick();
    check("t4_no_ivalid", {31'd0, IValid}, 32'd0);
    check("t4_busy_drop", {31'd0, Busy}, 32'd0);
    DReq = 1; DAddr = 32'h0000_3000;
    tick();
    check("t4_dready", {31'd0, DReady}, 32'd1);
    sbQ.push_back('{1'b1, 32'h7777_7777, 1'b0, 1'b1});
    DReq = 0; gntDrv = 1; rvDrv = 1; MemRdata = 32'h7777_7777;
    tick();
    gntDrv = 0; rvDrv = 0;
    check("t4_no_early_dvalid", {31'd0, DValid}, 32'd0);
    tick();
    check("t4_dvalid", {31'd0, DValid}, 32'd1);

    // 5: granted but never answered -> timeout error
    DReq = 1; DAddr = 32'h0000_4000;
    tick();
    check("t5_dready", {31'd0, DReady}, 32'd1);
    sbQ.push_back('{1'b1, 32'd0, 1'b1, 1'b1});
    DReq = 0; gntDrv = 1;
    validAt = -1;
    for (int n = 1; n <= TIMEOUT + 10; n++) begin
      tick();
      gntDrv = 0;
      if (DValid && validAt < 0) begin
        validAt = n;
        check("t5_derr", {31'd0, DErr}, 32'd1);
        check("t5_drdata", DRdata, 32'd0);
      end
    end
    check("t5_latency", validAt, TIMEOUT + 2);

    // 6: reset in WAIT, then a stray rvalid
    DReq = 1; DAddr = 32'h0000_5000;
    tick();
    check("t6_dready", {31'd0, DReady}, 32'd1);
    DReq = 0; gntDrv = 1;
    tick();
    gntDrv = 0;
    tick();
    check("t6_busy_wait", {31'd0, Busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("t6_async_ctrl", {24'd0, IReady, IValid, IErr, DReady, DValid, DErr, MemReq, Busy}, 32'd0);
    check("t6_async_addr", MemAddr, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rvDrv = 1; MemRdata = 32'h9999_9999;
    tick();
    rvDrv = 0;
    tick(); tick(); tick();
    check("t6_no_dvalid", {31'd0, DValid}, 32'd0);
    check("t6_busy_idle", {31'd0, Busy}, 32'd0);

    check("sb_drained", sbQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
